// File: rtl/branch_predictor_pht_pkg.sv
// Shared constants and helpers for the pattern history table and the fetch-stage index pipe.
package branch_predictor_pht_pkg;

    localparam int unsigned MAX_PC_BITS    = 64;
    localparam int unsigned MAX_INDEX_BITS = 32;

    // Reset value of a counter: weakly not-taken (0 for a 1-bit counter).
    function automatic int unsigned weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_bits);
        return 32'((64'd1 << ctr_bits) - 64'd1);
    endfunction

    // gshare hash: word-aligned PC bits XOR zero-extended history, masked to the table depth.
    function automatic logic [MAX_INDEX_BITS-1:0] index_hash(
        input logic [MAX_PC_BITS-1:0]    pc,
        input logic [MAX_INDEX_BITS-1:0] ghr,
        input int unsigned               index_bits
    );
        logic [MAX_INDEX_BITS-1:0] pc_bits;
        logic [MAX_INDEX_BITS-1:0] mask;
        pc_bits = MAX_INDEX_BITS'(pc >> 2);
        mask    = MAX_INDEX_BITS'((64'd1 << index_bits) - 64'd1);
        return (pc_bits ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/branch_predictor_pht_if.sv
// Lookup and update bus between the fetch/execute stages and the pattern history table.
interface branch_predictor_pht_if #(
    parameter int unsigned PC_BITS    = 32,
    parameter int unsigned INDEX_BITS = 6
);
    logic [PC_BITS-1:0]    lookup_pc;
    logic                  lookup_taken;
    logic [INDEX_BITS-1:0] lookup_index;
    logic                  update_en;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;

    modport master (
        output lookup_pc, update_en, update_index, update_taken,
        input  lookup_taken, lookup_index
    );

    modport slave (
        input  lookup_pc, update_en, update_index, update_taken,
        output lookup_taken, lookup_index
    );
endinterface

// File: rtl/branch_predictor_pht_sat_ctr_next.sv
// Next-state logic for one unsigned saturating counter.
module sat_ctr_next
    import branch_predictor_pht_pkg::*;
#(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] count,
    input  logic                taken,
    output logic [CTR_BITS-1:0] next_count_c
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

    always_comb begin
        next_count_c = count;
        if (taken) begin
            if (count != CTR_MAX) next_count_c = count + CTR_BITS'(1);
        end else begin
            if (count != '0) next_count_c = count - CTR_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor_pht.sv
// Pattern history table of saturating counters with optional gshare history.
module branch_predictor_pht
    import branch_predictor_pht_pkg::*;
#(
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned HIST_BITS  = 4,
    parameter int unsigned PC_BITS    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    branch_predictor_pht_if.slave  bus
);
    localparam int unsigned         DEPTH     = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] RESET_VAL = CTR_BITS'(weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0]   table_q [DEPTH];
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] lookup_index_c;
    logic [CTR_BITS-1:0]   ctr_next_c;

    if (CTR_BITS < 1) begin : g_bad_ctr
        $error("CTR_BITS must be at least 1");
    end
    if (HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("HIST_BITS must not exceed INDEX_BITS");
    end
    if (PC_BITS < INDEX_BITS + 2) begin : g_bad_pc
        $error("PC_BITS must be at least INDEX_BITS+2");
    end

    // History is only committed from resolved branches, so it never needs repair.
    if (HIST_BITS == 0) begin : g_bimodal
        assign ghr_ext = '0;
    end else begin : g_ghr
        logic [HIST_BITS-1:0] ghr_q;
        always_ff @(posedge clock) begin
            if (reset) begin
                ghr_q <= '0;
            end else if (bus.update_en) begin
                ghr_q <= HIST_BITS'({ghr_q, bus.update_taken});
            end
        end
        assign ghr_ext = INDEX_BITS'(ghr_q);
    end

    assign lookup_index_c = INDEX_BITS'(index_hash(MAX_PC_BITS'(bus.lookup_pc),
                                                   MAX_INDEX_BITS'(ghr_ext), INDEX_BITS));
    assign bus.lookup_index = lookup_index_c;
    assign bus.lookup_taken = table_q[lookup_index_c][CTR_BITS-1];

    sat_ctr_next #(.CTR_BITS(CTR_BITS)) u_sat_ctr_next (
        .count        (table_q[bus.update_index]),
        .taken        (bus.update_taken),
        .next_count_c (ctr_next_c)
    );

    // Flop array rather than RAM: whole-table reset in one cycle and an unregistered read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= RESET_VAL;
        end else if (bus.update_en) begin
            table_q[bus.update_index] <= ctr_next_c;
        end
    end
endmodule

// File: tb/tb_branch_predictor_pht.sv
// Self-checking bench: gshare default, bimodal and 3-bit-counter builds share one clock and reset.
module tb_branch_predictor_pht;

    logic clk;
    logic rst;

    branch_predictor_pht_if #(.PC_BITS(32), .INDEX_BITS(6)) bus_gs ();
    branch_predictor_pht_if #(.PC_BITS(32), .INDEX_BITS(6)) bus_bi ();
    branch_predictor_pht_if #(.PC_BITS(32), .INDEX_BITS(6)) bus_c3 ();

    branch_predictor_pht u_gs (.clock(clk), .reset(rst), .bus(bus_gs));
    branch_predictor_pht #(.HIST_BITS(0)) u_bi (.clock(clk), .reset(rst), .bus(bus_bi));
    branch_predictor_pht #(.CTR_BITS(3)) u_c3 (.clock(clk), .reset(rst), .bus(bus_c3));

    typedef struct {
        int unsigned dut;
        logic        taken;
        logic [5:0]  idx;
        string       name;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t sb_e;
    logic     obs_t;
    logic [5:0] obs_i;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every expectation pushed this cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (sb_q.size() != 0) begin
            sb_e = sb_q.pop_front();
            case (sb_e.dut)
                0:       begin obs_t = bus_gs.lookup_taken; obs_i = bus_gs.lookup_index; end
                1:       begin obs_t = bus_bi.lookup_taken; obs_i = bus_bi.lookup_index; end
                default: begin obs_t = bus_c3.lookup_taken; obs_i = bus_c3.lookup_index; end
            endcase
            checks++;
            if (obs_t !== sb_e.taken || obs_i !== sb_e.idx) begin
                errors++;
                $display("FAIL %s: got taken=%0b index=0x%02h, want taken=%0b index=0x%02h",
                         sb_e.name, obs_t, obs_i, sb_e.taken, sb_e.idx);
            end
        end
    end

    task automatic expect_lookup(input int unsigned dut, input logic t, input logic [5:0] i,
                                 input string n);
        sb_item_t it;
        it.dut = dut; it.taken = t; it.idx = i; it.name = n;
        sb_q.push_back(it);
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_gs.update_en = 1'b0;
        bus_bi.update_en = 1'b0;
        bus_c3.update_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        next_drive();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bus_gs.lookup_pc = 32'h0000_0040;
        bus_bi.lookup_pc = 32'h0000_0040;
        bus_c3.lookup_pc = 32'h0000_0040;
        expect_lookup(0, 1'b0, 6'h10, "reset_gs");
        expect_lookup(1, 1'b0, 6'h10, "reset_bi");
        expect_lookup(2, 1'b0, 6'h10, "reset_c3");
        @(negedge clk);
        checks++;
        if (u_c3.table_q[16] !== 3'd3) begin
            errors++;
            $display("FAIL reset_c3_ctr: got %0d want 3", u_c3.table_q[16]);
        end
        checks++;
        if (u_gs.table_q[63] !== 2'd1) begin
            errors++;
            $display("FAIL reset_gs_ctr: got %0d want 1", u_gs.table_q[63]);
        end
        next_drive();
    endtask

    task automatic test_saturation_up();
        int m;
        do_reset();
        m = 1;
        for (int k = 0; k < 6; k++) begin
            bus_bi.update_en    = 1'b1;
            bus_bi.update_index = 6'd5;
            bus_bi.update_taken = 1'b1;
            bus_bi.lookup_pc    = 32'h0000_0014;
            expect_lookup(1, logic'(m >= 2), 6'd5, "sat_up");
            m = (m < 3) ? m + 1 : 3;
            next_drive();
        end
        bus_bi.update_en = 1'b0;
        expect_lookup(1, 1'b1, 6'd5, "sat_up_final");
        @(negedge clk);
        checks++;
        if (u_bi.table_q[5] !== 2'd3) begin
            errors++;
            $display("FAIL sat_up_ctr: got %0d want 3", u_bi.table_q[5]);
        end
        next_drive();
    endtask

    task automatic test_saturation_down();
        int m;
        m = 3;
        for (int k = 0; k < 5; k++) begin
            bus_bi.update_en    = 1'b1;
            bus_bi.update_index = 6'd5;
            bus_bi.update_taken = 1'b0;
            bus_bi.lookup_pc    = 32'h0000_0014;
            expect_lookup(1, logic'(m >= 2), 6'd5, "sat_down");
            m = (m > 0) ? m - 1 : 0;
            next_drive();
            if (k == 1) begin
                checks++;
                if (u_bi.table_q[5] !== 2'd1) begin
                    errors++;
                    $display("FAIL sat_down_mid: got %0d want 1", u_bi.table_q[5]);
                end
            end
        end
        bus_bi.update_en = 1'b0;
        expect_lookup(1, 1'b0, 6'd5, "sat_down_final");
        @(negedge clk);
        checks++;
        if (u_bi.table_q[5] !== 2'd0) begin
            errors++;
            $display("FAIL sat_down_nowrap: got %0d want 0", u_bi.table_q[5]);
        end
        next_drive();
    endtask

    task automatic test_conflict();
        do_reset();
        bus_bi.update_en    = 1'b1;
        bus_bi.update_index = 6'd7;
        bus_bi.update_taken = 1'b1;
        bus_bi.lookup_pc    = 32'h0000_001C;
        expect_lookup(1, 1'b0, 6'd7, "conflict_same_cycle");
        next_drive();
        bus_bi.update_en = 1'b0;
        expect_lookup(1, 1'b1, 6'd7, "conflict_next_cycle");
        next_drive();
    endtask

    task automatic test_gshare();
        logic [3:0] g;
        logic       pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        do_reset();
        g = 4'h0;
        for (int k = 0; k < 4; k++) begin
            bus_gs.update_en    = 1'b1;
            bus_gs.update_index = 6'd0;
            bus_gs.update_taken = pat[k];
            bus_gs.lookup_pc    = 32'h0000_0000;
            expect_lookup(0, 1'b0, {2'b00, g}, "gshare_pre_update_ghr");
            g = {g[2:0], pat[k]};
            next_drive();
        end
        bus_gs.update_en = 1'b0;
        expect_lookup(0, 1'b0, 6'h0B, "gshare_hist_1011");
        @(negedge clk);
        checks++;
        if (u_gs.g_ghr.ghr_q !== 4'b1011) begin
            errors++;
            $display("FAIL gshare_ghr: got %04b want 1011", u_gs.g_ghr.ghr_q);
        end
        next_drive();
        bus_gs.lookup_pc = 32'h0000_002C;
        expect_lookup(0, 1'b1, 6'h00, "gshare_xor_hits_trained");
        next_drive();
    endtask

    task automatic test_reset_priority();
        bus_gs.update_en    = 1'b1;
        bus_gs.update_index = 6'd2;
        bus_gs.update_taken = 1'b1;
        bus_c3.update_en    = 1'b1;
        bus_c3.update_index = 6'd2;
        bus_c3.update_taken = 1'b1;
        rst = 1'b1;
        next_drive();
        rst = 1'b0;
        idle_all();
        bus_gs.lookup_pc = 32'h0000_0008;
        bus_c3.lookup_pc = 32'h0000_0008;
        expect_lookup(0, 1'b0, 6'd2, "rstprio_gs_lookup");
        expect_lookup(2, 1'b0, 6'd2, "rstprio_c3_lookup");
        @(negedge clk);
        checks++;
        if (u_gs.table_q[2] !== 2'd1 || u_gs.table_q[0] !== 2'd1) begin
            errors++;
            $display("FAIL rstprio_gs_ctr: got %0d/%0d want 1/1", u_gs.table_q[2], u_gs.table_q[0]);
        end
        checks++;
        if (u_gs.g_ghr.ghr_q !== 4'd0) begin
            errors++;
            $display("FAIL rstprio_ghr: got %04b want 0000", u_gs.g_ghr.ghr_q);
        end
        checks++;
        if (u_c3.table_q[2] !== 3'd3) begin
            errors++;
            $display("FAIL rstprio_c3_ctr: got %0d want 3", u_c3.table_q[2]);
        end
        next_drive();
        // One taken update lifts the 3-bit counter from 3 to weak-taken 4.
        bus_c3.update_en    = 1'b1;
        bus_c3.update_index = 6'd2;
        bus_c3.update_taken = 1'b1;
        expect_lookup(2, 1'b0, 6'd2, "c3_pre_update");
        next_drive();
        bus_c3.update_en = 1'b0;
        bus_c3.lookup_pc = 32'h0000_000C;
        expect_lookup(2, 1'b1, 6'd2, "c3_weak_taken");
        @(negedge clk);
        checks++;
        if (u_c3.table_q[2] !== 3'd4) begin
            errors++;
            $display("FAIL c3_ctr_after_update: got %0d want 4", u_c3.table_q[2]);
        end
        next_drive();
    endtask

    task automatic test_back_to_back();
        int         m [64];
        logic [31:0] pc;
        logic [5:0]  li;
        logic [5:0]  ui;
        logic        ut;
        logic        ue;
        do_reset();
        for (int i = 0; i < 64; i++) m[i] = 1;
        for (int k = 0; k < 400; k++) begin
            pc = $urandom;
            li = pc[7:2];
            ue = logic'($urandom_range(0, 3) != 0);
            ui = 6'($urandom_range(0, 15));
            ut = logic'($urandom_range(0, 2) != 0) ^ ui[0];
            bus_bi.lookup_pc    = pc;
            bus_bi.update_en    = ue;
            bus_bi.update_index = ui;
            bus_bi.update_taken = ut;
            expect_lookup(1, logic'(m[li] >= 2), li, "b2b_random");
            if (ue) begin
                if (ut) m[ui] = (m[ui] < 3) ? m[ui] + 1 : 3;
                else    m[ui] = (m[ui] > 0) ? m[ui] - 1 : 0;
            end
            next_drive();
        end
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        bus_gs.lookup_pc = '0; bus_gs.update_en = 1'b0; bus_gs.update_index = '0; bus_gs.update_taken = 1'b0;
        bus_bi.lookup_pc = '0; bus_bi.update_en = 1'b0; bus_bi.update_index = '0; bus_bi.update_taken = 1'b0;
        bus_c3.lookup_pc = '0; bus_c3.update_en = 1'b0; bus_c3.update_index = '0; bus_c3.update_taken = 1'b0;
        next_drive();
        test_reset();
        test_saturation_up();
        test_saturation_down();
        test_conflict();
        test_gshare();
        test_reset_priority();
        test_back_to_back();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
